uart_fifo_os: RTL and testbench

UART_FIFO_OS -- requirements
Module: uart_fifo_os

---
 rtl/uart_fifo_os.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_os.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_os.sv
// uart_fifo_os: UART with TX/RX FIFOs and an oversampling receiver.
// Ports: clk/rst_n; frame cfg (char_length, stop_bits, parity_mode, baud_div);
//  tx_data/tx_load -> TX FIFO (tx_full/empty/level/busy);
//  RX FIFO head rx_data/rx_valid/flags, rx_read pop, rx_level;
//  overrun_error/ovr_clr, break_det; serial_out/serial_in line.
module uart_fifo_os #(
  parameter int FIFO_DEPTH = 16,
  parameter int OS         = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    char_length,
  input  logic [1:0]    stop_bits,
  input  logic [1:0]    parity_mode,
  input  logic [15:0]   baud_div,
  input  logic [7:0]    tx_data,
  input  logic          tx_load,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [LW-1:0] tx_level,
  output logic          tx_busy,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_read,
  output logic          rx_framing_err,
  output logic          rx_parity_err,
  output logic [LW-1:0] rx_level,
  output logic          overrun_error,
  input  logic          ovr_clr,
  output logic          break_det,
  output logic          serial_out,
  input  logic          serial_in
);

  localparam int CW = $clog2(2 * OS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_e;

  function automatic logic [7:0] dmask(input logic [1:0] cl);
    return 8'hFF >> (2'd3 - cl);
  endfunction

  // ---------------- prescaler
  logic [15:0] presc_q;
  logic        tick;

  // >= keeps a lowered baud_div from waiting out a full wrap
  assign tick = (presc_q >= baud_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + 16'd1;
  end

  // ---------------- TX FIFO
  logic [7:0]    txm [FIFO_DEPTH];
  logic [AW-1:0] txw_q, txr_q;
  logic [LW-1:0] txc_q;
  logic          tx_push, tx_pop;
  logic [7:0]    tx_head;
  logic          tx_head_par;

  assign tx_full  = (txc_q == LW'(FIFO_DEPTH));
  assign tx_empty = (txc_q == '0);
  assign tx_level = txc_q;
  assign tx_push  = tx_load && !tx_full;

  assign tx_head     = txm[txr_q] & dmask(char_length);
  assign tx_head_par = (parity_mode == 2'b01) ? ~^tx_head : ^tx_head;

  always_ff @(posedge clk) begin
    if (tx_push) txm[txw_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txw_q <= '0;
      txr_q <= '0;
      txc_q <= '0;
    end else begin
      if (tx_push) txw_q <= txw_q + AW'(1);
      if (tx_pop)  txr_q <= txr_q + AW'(1);
      txc_q <= txc_q + LW'(tx_push) - LW'(tx_pop);
    end
  end

  // ---------------- TX FSM
  st_e           tx_st_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic [1:0]    tx_cl_q, tx_sb_q;
  logic          tx_pen_q, tx_pbit_q;
  logic          so_q, busy_q;
  logic [CW-1:0] tx_stop_last;
  logic          tx_bit_end, tx_stop_end;
  logic [2:0]    tx_last;

  always_comb begin
    case (tx_sb_q)
      2'b00:   tx_stop_last = CW'(OS - 1);
      2'b01:   tx_stop_last = CW'(OS * 3 / 2 - 1);
      default: tx_stop_last = CW'(2 * OS - 1);
    endcase
  end

  assign tx_bit_end  = (tx_cnt_q == CW'(OS - 1));
  assign tx_stop_end = (tx_cnt_q == tx_stop_last);
  assign tx_last     = 3'd4 + {1'b0, tx_cl_q};

  // pop at idle or exactly at the end of a stop bit: no gap
  assign tx_pop = tick && !tx_empty &&
                  (tx_st_q == S_IDLE ||
                   (tx_st_q == S_STOP && tx_stop_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_cl_q   <= '0;
      tx_sb_q   <= '0;
      tx_pen_q  <= 1'b0;
      tx_pbit_q <= 1'b0;
      so_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (tick) begin
      tx_cnt_q <= tx_cnt_q + CW'(1);
      unique case (tx_st_q)
        S_IDLE: tx_cnt_q <= '0;
        S_START: begin
          if (tx_bit_end) begin
            tx_st_q  <= S_DATA;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            so_q     <= tx_sh_q[0];
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == tx_last) begin
              tx_st_q <= tx_pen_q ? S_PAR : S_STOP;
              so_q    <= tx_pen_q ? tx_pbit_q : 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= tx_sh_q >> 1;
              so_q     <= tx_sh_q[1];
            end
          end
        end
        S_PAR: begin
          if (tx_bit_end) begin
            tx_st_q  <= S_STOP;
            tx_cnt_q <= '0;
            so_q     <= 1'b1;
          end
        end
        S_STOP: begin
          if (tx_stop_end) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            so_q     <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: tx_st_q <= S_IDLE;
      endcase
      // a new character overrides the idle/stop exit above
      if (tx_pop) begin
        tx_st_q   <= S_START;
        tx_cnt_q  <= '0;
        tx_sh_q   <= tx_head;
        tx_cl_q   <= char_length;
        tx_sb_q   <= stop_bits;
        tx_pen_q  <= ^parity_mode;
        tx_pbit_q <= tx_head_par;
        so_q      <= 1'b0;
        busy_q    <= 1'b1;
      end
    end
  end

  assign serial_out = so_q;
  assign tx_busy    = busy_q;

  // ---------------- RX synchronizer
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], serial_in};
  end

  assign rx_s = sync_q[1];

  // ---------------- RX FSM
  st_e           rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic [1:0]    rx_cl_q, rx_pm_q;
  logic          rx_pbit_q, rx_hold_q;
  logic          push_q, brk_q;
  logic [9:0]    pdat_q;
  logic          rx_pen, rx_bit_end, rx_perr;

  assign rx_pen     = ^rx_pm_q;
  assign rx_bit_end = (rx_cnt_q == CW'(OS - 1));
  assign rx_perr    = rx_pen &
                      (^rx_sh_q ^ rx_pbit_q ^ (rx_pm_q == 2'b01));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_cl_q   <= '0;
      rx_pm_q   <= '0;
      rx_pbit_q <= 1'b0;
      rx_hold_q <= 1'b0;
      push_q    <= 1'b0;
      brk_q     <= 1'b0;
      pdat_q    <= '0;
    end else begin
      push_q <= 1'b0;
      brk_q  <= 1'b0;
      if (tick) begin
        rx_cnt_q <= rx_cnt_q + CW'(1);
        unique case (rx_st_q)
          S_IDLE: begin
            rx_cnt_q <= '0;
            if (rx_hold_q) begin
              if (rx_s) rx_hold_q <= 1'b0;
            end else if (!rx_s) begin
              rx_st_q   <= S_START;
              rx_sh_q   <= '0;
              rx_pbit_q <= 1'b0;
              rx_cl_q   <= char_length;
              rx_pm_q   <= parity_mode;
            end
          end
          S_START: begin
            // this tick is OS/2-1 ticks past detection
            if (rx_cnt_q == CW'(OS / 2 - 2)) begin
              rx_cnt_q <= '0;
              rx_bit_q <= '0;
              rx_st_q  <= rx_s ? S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            if (rx_bit_end) begin
              rx_cnt_q          <= '0;
              rx_sh_q[rx_bit_q] <= rx_s;
              if (rx_bit_q == 3'd4 + {1'b0, rx_cl_q})
                rx_st_q <= rx_pen ? S_PAR : S_STOP;
              else
                rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
          S_PAR: begin
            if (rx_bit_end) begin
              rx_cnt_q  <= '0;
              rx_pbit_q <= rx_s;
              rx_st_q   <= S_STOP;
            end
          end
          S_STOP: begin
            if (rx_bit_end) begin
              rx_cnt_q <= '0;
              rx_st_q  <= S_IDLE;
              push_q   <= 1'b1;
              pdat_q   <= {rx_perr, ~rx_s, rx_sh_q};
              if (rx_sh_q == 8'd0 && !rx_pbit_q && !rx_s) begin
                brk_q     <= 1'b1;
                rx_hold_q <= 1'b1;
              end
            end
          end
          default: rx_st_q <= S_IDLE;
        endcase
      end
    end
  end

  assign break_det = brk_q;

  // ---------------- RX FIFO
  logic [9:0]    rxm [FIFO_DEPTH];
  logic [AW-1:0] rxw_q, rxr_q;
  logic [LW-1:0] rxc_q;
  logic          ovr_q;
  logic          rx_full, rx_pop, rx_wr, rx_ovf;
  logic [9:0]    rx_head;

  assign rx_full = (rxc_q == LW'(FIFO_DEPTH));
  assign rx_pop  = rx_read && rx_valid;
  // a same-cycle pop frees the slot the push needs
  assign rx_wr   = push_q && (!rx_full || rx_pop);
  assign rx_ovf  = push_q && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_wr) rxm[rxw_q] <= pdat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxw_q <= '0;
      rxr_q <= '0;
      rxc_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (rx_wr)  rxw_q <= rxw_q + AW'(1);
      if (rx_pop) rxr_q <= rxr_q + AW'(1);
      rxc_q <= rxc_q + LW'(rx_wr) - LW'(rx_pop);
      if (ovr_clr)     ovr_q <= 1'b0;
      else if (rx_ovf) ovr_q <= 1'b1;
    end
  end

  assign rx_valid       = (rxc_q != '0);
  assign rx_level       = rxc_q;
  assign rx_head        = rx_valid ? rxm[rxr_q] : 10'd0;
  assign rx_data        = rx_head[7:0];
  assign rx_framing_err = rx_head[8];
  assign rx_parity_err  = rx_head[9];
  assign overrun_error  = ovr_q;

endmodule

// File: tb/tb_uart_fifo_os.sv
// tb_uart_fifo_os: randomized bench for uart_fifo_os.
// Line waveforms and received bytes come from a frame-level model.
module tb_uart_fifo_os;

  localparam int DEPTH = 4;
  localparam int OS    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    char_length, stop_bits, parity_mode;
  logic [15:0]   baud_div;
  logic [7:0]    tx_data;
  logic          tx_load;
  logic          tx_full, tx_empty, tx_busy;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_read;
  logic          rx_framing_err, rx_parity_err;
  logic          overrun_error, ovr_clr, break_det;
  logic          serial_out, serial_in;
  logic          loop, rx_drv;

  int n_chk = 0;
  int n_err = 0;
  int brk_cnt = 0;

  bit       wave[$];
  bit [7:0] txq[$];

  always #5 clk = ~clk;

  assign serial_in = loop ? serial_out : rx_drv;

  always @(posedge clk) if (break_det) brk_cnt++;

  uart_fifo_os #(.FIFO_DEPTH(DEPTH), .OS(OS)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_length(char_length), .stop_bits(stop_bits),
    .parity_mode(parity_mode), .baud_div(baud_div),
    .tx_data(tx_data), .tx_load(tx_load),
    .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_level(tx_level), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_framing_err(rx_framing_err),
    .rx_parity_err(rx_parity_err), .rx_level(rx_level),
    .overrun_error(overrun_error), .ovr_clr(ovr_clr),
    .break_det(break_det),
    .serial_out(serial_out), .serial_in(serial_in)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dmask(input logic [1:0] cl);
    return 8'((1 << (5 + int'(cl))) - 1);
  endfunction

  // One frame as per-tick line levels (one tick per clock at baud_div=0)
  function automatic void add_frame(input logic [7:0] d,
                                    input logic [1:0] cl,
                                    input logic [1:0] sb,
                                    input logic [1:0] pm);
    int nb, ones, st;
    nb = 5 + int'(cl);
    ones = 0;
    repeat (OS) wave.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) wave.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 2'b01) repeat (OS) wave.push_back(ones % 2 == 0);
    if (pm == 2'b10) repeat (OS) wave.push_back(ones % 2 == 1);
    st = (sb == 2'b00) ? OS : (sb == 2'b01) ? OS * 3 / 2 : 2 * OS;
    repeat (st) wave.push_back(1'b1);
  endfunction

  task automatic tx_run(input string tag);
    int k, tot, bad_line, bad_busy;
    k = txq.size();
    wave.delete();
    foreach (txq[i])
      add_frame(txq[i], char_length, stop_bits, parity_mode);
    repeat (OS) wave.push_back(1'b1);
    tot = wave.size();
    bad_line = 0;
    bad_busy = 0;
    for (int c = 0; c < tot + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        if (serial_out !== wave[c-2]) bad_line++;
        if (tx_busy !== ((c - 2) < (tot - OS))) bad_busy++;
      end
      tx_load = (c < k);
      if (c < k) tx_data = txq[c];
    end
    check({tag, " line errs"}, bad_line, 0);
    check({tag, " busy errs"}, bad_busy, 0);
    check({tag, " tx_empty"}, tx_empty, 1);
  endtask

  task automatic play_wave();
    foreach (wave[i]) begin
      @(negedge clk);
      rx_drv = wave[i];
    end
    @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic wait_rx(input int k, input string tag);
    int t;
    t = 0;
    while (rx_level != LW'(k) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " rx_level"}, rx_level, k);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && rx_valid; i++) pop();
  endtask

  task automatic lb_run(input string tag);
    int k, t;
    k = txq.size();
    loop = 1'b1;
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      tx_load = 1'b1;
      tx_data = txq[c];
    end
    @(negedge clk);
    tx_load = 1'b0;
    wait_rx(k, tag);
    foreach (txq[i]) begin
      check({tag, " data"}, rx_data, txq[i] & dmask(char_length));
      check({tag, " ferr"}, rx_framing_err, 0);
      check({tag, " perr"}, rx_parity_err, 0);
      pop();
    end
    t = 0;
    while (tx_busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " tx done"}, tx_busy, 0);
    check({tag, " overrun"}, overrun_error, 0);
    repeat (8 * (int'(baud_div) + 1)) @(negedge clk);
    loop = 1'b0;
  endtask

  initial begin
    int b0;
    logic [7:0] first;
    rst_n = 1'b0;
    loop = 1'b0;
    rx_drv = 1'b1;
    baud_div = 16'd0;
    char_length = 2'b11;
    stop_bits = 2'b00;
    parity_mode = 2'b00;
    tx_data = 8'h00;
    tx_load = 1'b0;
    rx_read = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst serial_out", serial_out, 1);
    check("rst tx_busy", tx_busy, 0);
    check("rst tx_empty", tx_empty, 1);
    check("rst tx_full", tx_full, 0);
    check("rst tx_level", tx_level, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx_level", rx_level, 0);
    check("rst rx_data", rx_data, 0);
    check("rst flags", {rx_framing_err, rx_parity_err}, 0);
    check("rst overrun", overrun_error, 0);
    check("rst break", break_det, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    txq = '{8'h55};
    tx_run("tx 55 8N1");

    char_length = 2'b10;
    stop_bits = 2'b10;
    parity_mode = 2'b01;
    txq = '{8'h41, 8'h7F};
    tx_run("tx 7O2");

    for (int r = 0; r < 5; r++) begin
      char_length = 2'($urandom_range(0, 3));
      stop_bits = 2'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      txq.delete();
      repeat ($urandom_range(1, 3)) txq.push_back(8'($urandom));
      tx_run("tx rand");
    end

    char_length = 2'b10;
    stop_bits = 2'b10;
    parity_mode = 2'b01;
    txq = '{8'h41, 8'h7F};
    lb_run("lb 7O2");

    for (int r = 0; r < 4; r++) begin
      baud_div = 16'($urandom_range(0, 3));
      char_length = 2'($urandom_range(0, 3));
      stop_bits = 2'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      txq.delete();
      repeat ($urandom_range(1, DEPTH)) txq.push_back(8'($urandom));
      lb_run("lb rand");
    end

    baud_div = 16'd0;
    char_length = 2'b11;
    stop_bits = 2'b00;
    parity_mode = 2'b00;
    repeat (4) @(negedge clk);

    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch no push", rx_level, 0);
    wave.delete();
    add_frame(8'hA5, 2'b11, 2'b00, 2'b00);
    play_wave();
    repeat (20) @(negedge clk);
    check("post-glitch level", rx_level, 1);
    check("post-glitch data", rx_data, 8'hA5);
    drain();

    wave.delete();
    first = 8'($urandom);
    add_frame(first, 2'b11, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++)
      add_frame(8'($urandom), 2'b11, 2'b00, 2'b00);
    play_wave();
    repeat (20) @(negedge clk);
    check("ovr level", rx_level, DEPTH);
    check("ovr flag", overrun_error, 1);
    check("ovr head", rx_data, first);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr clr", overrun_error, 0);
    check("ovr clr level", rx_level, DEPTH);
    drain();
    check("drained", rx_level, 0);
    pop();
    check("empty pop level", rx_level, 0);
    check("empty pop valid", rx_valid, 0);

    parity_mode = 2'b10;
    b0 = brk_cnt;
    rx_drv = 1'b0;
    repeat (12 * OS) @(negedge clk);
    check("brk level", rx_level, 1);
    check("brk data", rx_data, 8'h00);
    check("brk ferr", rx_framing_err, 1);
    check("brk perr", rx_parity_err, 0);
    check("brk pulses", brk_cnt - b0, 1);
    rx_drv = 1'b1;
    repeat (4 * OS) @(negedge clk);
    check("brk no repush", rx_level, 1);
    check("brk pulses after", brk_cnt - b0, 1);
    drain();

    parity_mode = 2'b00;
    baud_div = 16'd1000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tx_load = 1'b1;
      tx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    tx_load = 1'b0;
    check("tx full", tx_full, 1);
    check("tx full level", tx_level, DEPTH);
    baud_div = 16'd0;
    repeat (40) @(negedge clk);
    check("mid level", tx_level, DEPTH - 1);
    check("mid busy", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst serial_out", serial_out, 1);
    check("arst tx_level", tx_level, 0);
    check("arst tx_busy", tx_busy, 0);
    check("arst tx_empty", tx_empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
